// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request, result and adder-side signals of the nibble-serial add/sub sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface nibble_serial_addsub_ctrl_if #(
    parameter int NIBBLES = 2
);
    localparam int WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       adder_a;
    logic [3:0]       adder_b;
    logic             adder_cin;
    logic [3:0]       adder_s;
    logic             adder_cout;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_ovf;
    logic             res_zero;

    modport slave (
        input  in_valid, op_sub, op_a, op_b, adder_s, adder_cout, res_ready,
        output in_ready, adder_a, adder_b, adder_cin,
               res_valid, res_sum, res_cout, res_ovf, res_zero
    );

    modport master (
        output in_valid, op_sub, op_a, op_b, adder_s, adder_cout, res_ready,
        input  in_ready, adder_a, adder_b, adder_cin,
               res_valid, res_sum, res_cout, res_ovf, res_zero
    );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Streams a WIDTH-bit add/subtract through an external 4-bit ripple adder,
// one nibble per cycle LSB first, and hands the result off via valid/ready.
module nibble_serial_addsub_ctrl #(
    parameter int NIBBLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    nibble_serial_addsub_ctrl_if.slave  bus
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDXW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_c;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_ovf;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        bus.adder_a   = '0;
        bus.adder_b   = '0;
        bus.adder_cin = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_next = S_CALC;
            end
            S_CALC: begin
                // The adder inverts B whenever Cin=1, so pre-invert by (sub ^ c)
                // to get A + (sub ? ~B : B) + c on every nibble.
                bus.adder_a   = r_a[r_idx*4 +: 4];
                bus.adder_b   = r_b[r_idx*4 +: 4] ^ {4{r_sub ^ r_c}};
                bus.adder_cin = r_c;
                if (r_idx == LAST) w_state_next = S_DONE;
            end
            S_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_acc_next = r_acc;
        w_acc_next[r_idx*4 +: 4] = bus.adder_s;
        w_ovf = (r_a[WIDTH-1] == (r_b[WIDTH-1] ^ r_sub)) &&
                (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
    end

    // Result registers load only on the final nibble so they hold across idle periods.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sub  <= 1'b0;
            r_c    <= 1'b0;
            r_idx  <= '0;
            r_acc  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a   <= bus.op_a;
                        r_b   <= bus.op_b;
                        r_sub <= bus.op_sub;
                        r_c   <= bus.op_sub;
                        r_idx <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_c   <= bus.adder_cout;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_sum  <= w_acc_next;
                        r_cout <= bus.adder_cout;
                        r_ovf  <= w_ovf;
                        r_zero <= (w_acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.res_sum  = r_sum;
    assign bus.res_cout = r_cout;
    assign bus.res_ovf  = r_ovf;
    assign bus.res_zero = r_zero;
endmodule
